frame_sequencer: RTL

Central controller for the image-processing datapath. It accepts a debounced start request and latches the operation mode (shrink or effect) and the effect code. It launches exactly one processing engine and owns the ROM read-address and FIFO write-port muxes while that engine runs. It then hands the frame to the UART path, waits for transmit completion, and reports status. The block also guards the whole operation with a watchdog and supports abort.

---
 rtl/frame_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// Frame-level controller: launches one image engine, muxes its ROM/FIFO ports,
// hands the frame to the UART path and guards the whole run with a watchdog.
module frame_sequencer #(
    parameter int HIEGHT  = 30,
    parameter int WIDTH   = 30,
    parameter int BPP     = 3,
    parameter int SZ      = 8 * BPP,
    parameter int AW      = 10,
    parameter int TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          shr_or_eff,
    input  logic [1:0]    effect,
    input  logic          abort,
    input  logic [AW-1:0] sh_rd_addr,
    input  logic [AW-1:0] eff_rd_addr,
    input  logic [AW-1:0] sh_wr_addr,
    input  logic [AW-1:0] eff_wr_addr,
    input  logic [SZ-1:0] sh_pixel,
    input  logic [SZ-1:0] eff_pixel,
    input  logic          sh_done,
    input  logic          eff_done,
    input  logic          tx_done,
    output logic          start_shrink,
    output logic          start_effects,
    output logic [1:0]    eff_sel,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] wr_addr,
    output logic [SZ-1:0] pixel_out,
    output logic          wr_en,
    output logic          send,
    output logic          busy,
    output logic          op_done,
    output logic          frame_done,
    output logic          err,
    output logic [7:0]    frame_cnt
);

    if (HIEGHT * WIDTH > (1 << AW)) begin : g_aw_check
        $error("frame_sequencer: AW too narrow to address HIEGHT*WIDTH pixels");
    end

    typedef enum logic [2:0] {IDLE, LAUNCH, PROC, XMIT, DONE, ERR} state_e;

    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e         state_q, state_d;
    logic           mode_q, mode_d;
    logic [1:0]     eff_sel_q, eff_sel_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           op_done_q, op_done_d;
    logic [7:0]     frame_cnt_q, frame_cnt_d;
    logic           start_shrink_q, start_shrink_d;
    logic           start_effects_q, start_effects_d;
    logic           start_q, done_q, tx_meta_q, tx_s_q, tx_s_dly_q;

    logic start_rise, done_sel, done_rise, tx_rise, timeout_hit;

    assign start_rise  = start & ~start_q;
    assign done_sel    = mode_q ? sh_done : eff_done;
    assign done_rise   = done_sel & ~done_q;
    assign tx_rise     = tx_s_q & ~tx_s_dly_q;
    assign timeout_hit = (wd_q == WDW'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d         = state_q;
        mode_d          = mode_q;
        eff_sel_d       = eff_sel_q;
        wd_d            = wd_q;
        op_done_d       = op_done_q;
        frame_cnt_d     = frame_cnt_q;
        start_shrink_d  = 1'b0;
        start_effects_d = 1'b0;
        rd_addr         = '0;
        wr_addr         = '0;
        pixel_out       = '0;
        wr_en           = 1'b0;
        send            = 1'b0;
        busy            = 1'b0;
        frame_done      = 1'b0;
        err             = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_rise) begin
                    mode_d          = shr_or_eff;
                    eff_sel_d       = effect;
                    start_shrink_d  = shr_or_eff;
                    start_effects_d = ~shr_or_eff;
                    state_d         = LAUNCH;
                end
            end
            LAUNCH: begin
                busy      = 1'b1;
                wd_d      = '0;
                op_done_d = 1'b0;
                state_d   = PROC;
            end
            PROC: begin
                busy      = 1'b1;
                wr_en     = 1'b1;
                rd_addr   = mode_q ? sh_rd_addr : eff_rd_addr;
                wr_addr   = mode_q ? sh_wr_addr : eff_wr_addr;
                pixel_out = mode_q ? sh_pixel   : eff_pixel;
                wd_d      = wd_q + 1'b1;
                if (timeout_hit) begin
                    state_d = ERR;
                end else if (done_rise) begin
                    op_done_d = 1'b1;
                    state_d   = XMIT;
                end
            end
            XMIT: begin
                busy = 1'b1;
                send = 1'b1;
                wd_d = wd_q + 1'b1;
                if (timeout_hit) begin
                    state_d = ERR;
                end else if (tx_rise) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                frame_done  = 1'b1;
                frame_cnt_d = frame_cnt_q + 8'd1;
                state_d     = IDLE;
            end
            ERR: begin
                err = 1'b1;
                // Clearing the error consumes the edge; a fresh edge is needed to launch.
                if (start_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort outranks both the watchdog and any completion seen this cycle.
        if (abort && (state_q inside {LAUNCH, PROC, XMIT, DONE})) begin
            state_d     = IDLE;
            op_done_d   = 1'b0;
            frame_cnt_d = frame_cnt_q;
            frame_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            mode_q          <= 1'b0;
            eff_sel_q       <= 2'b00;
            wd_q            <= '0;
            op_done_q       <= 1'b0;
            frame_cnt_q     <= 8'd0;
            start_shrink_q  <= 1'b0;
            start_effects_q <= 1'b0;
            start_q         <= 1'b0;
            done_q          <= 1'b0;
            tx_meta_q       <= 1'b0;
            tx_s_q          <= 1'b0;
            tx_s_dly_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q         <= state_d;
            mode_q          <= mode_d;
            eff_sel_q       <= eff_sel_d;
            wd_q            <= wd_d;
            op_done_q       <= op_done_d;
            frame_cnt_q     <= frame_cnt_d;
            start_shrink_q  <= start_shrink_d;
            start_effects_q <= start_effects_d;
            start_q         <= start;
            done_q          <= done_sel;
            tx_meta_q       <= tx_done;
            tx_s_q          <= tx_meta_q;
            tx_s_dly_q      <= tx_s_q;
        end
    end

    assign start_shrink  = start_shrink_q;
    assign start_effects = start_effects_q;
    assign eff_sel       = eff_sel_q;
    assign op_done       = op_done_q;
    assign frame_cnt     = frame_cnt_q;

endmodule
